dsp_mac_sequencer: RTL
======================

Name: dsp_mac_sequencer

Overview:
- Control sequencer for one DSP48A1-style multiply-accumulate slice built from the team's registered-bypass pipeline stages: the A/B input registers, the M register and the P register.
- Accepts a job of LEN operand pairs over a valid/ready stream.
- Drives the per-stage clock enables and the accumulate/load select for the P-stage Z mux, then signals completion once the final sum is settled in the P register.
- Contains no datapath arithmetic; it sits beside the slice and is instantiated once per MAC channel.

Parameters:
- CNT_W, 10, width of job length and tap counter; max job = 2^CNT_W-1 taps.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs.
- start  in  1  job request; sampled only in IDLE.
- len  in  CNT_W  tap count for the job; sampled with start.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  sequencer accepts an operand pair.
- ce_ab  out  1  clock enable for the A/B input registers.
- ce_m  out  1  clock enable for the M register.
- ce_p  out  1  clock enable for the P register.
- opmode_acc  out  1  P-stage Z select: 0 = load P<=M, 1 = accumulate P<=P+M.
- busy  out  1  job in progress (state != IDLE).
- done  out  1  one-cycle pulse; P holds the final sum this cycle.
- err_len  out  1  one-cycle pulse; start with len==0 rejected.

Behaviour:
- Reset values: state=IDLE, remaining=0, first=0, v1=v2=f1=f2=0. Outputs after reset: in_ready=ce_ab=ce_m=ce_p=opmode_acc=busy=done=err_len=0.
- Handshake: hs = in_valid & in_ready. ce_ab = hs (combinational). in_ready = (state==RUN), driven from registered state only; it never depends on in_valid.
- Pipeline tracking, registered:
  - v1<=hs, f1<=first&hs.
  - v2<=v1, f2<=f1.
  - ce_m=v1, ce_p=v2.
  - opmode_acc = v2 & ~f2; 0 whenever ce_p=0.
- Latency: a pair accepted in cycle t gives ce_m in t+1 and ce_p in t+2. P is updated at the end of t+2.
- State IDLE:
  - start & len!=0 -> RUN; remaining<=len, first<=1.
  - start & len==0 -> err_len=1 next cycle; stay IDLE.
- State RUN:
  - On each hs: remaining<=remaining-1, first<=0.
  - hs & remaining==1 -> DRAIN.
  - in_valid low stalls with no timeout; pipeline bubbles propagate as ce gaps.
- State DRAIN:
  - in_ready=0.
  - Go to DONE when v2=1 & v1=0, i.e. the cycle of the last P update.
- State DONE: done=1 for exactly one cycle, then IDLE.
- From the last handshake in cycle L: DRAIN in L+1 and L+2, done in L+3, IDLE in L+4.
- start while busy (including DONE) is ignored and not queued.
- start in the cycle after done is accepted normally.
- len change during a job has no effect.
- Asynchronous rst mid-job: immediate return to IDLE, all ce outputs drop, no done pulse. The P-register contents are then undefined for the aborted job.
- Counter never wraps: it is loaded non-zero and exits at 1.

Optional Feature:
- Macro: DSP_SEQ_ABORT_EN.
- With the macro defined:
  - Extra input port abort (1 bit), sampled synchronously in any non-IDLE state.
  - On abort: next state IDLE, v1/v2/f1/f2 cleared, in_ready deasserted the next cycle.
  - Extra output rst_p pulses 1 for one cycle to synchronously clear the P register.
  - No done is generated for the aborted job.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Without the macro: the abort and rst_p ports do not exist; the only abort path is rst.

Test Plan:
- len=4, in_valid held 1, start in cycle 0 -> in_ready/ce_ab cycles 1-4; ce_m 2-5; ce_p 3-6; opmode_acc 0 in cycle 3 and 1 in 4-6; done in cycle 7 only; busy cycles 1-7.
- len=3, in_valid low in cycle 2 -> handshakes in cycles 1,3,4; ce_m 2,4,5; ce_p 3,5,6; done cycle 7. External MAC model with pairs (2,3),(4,5),(6,7) -> P=68 at done.
- start with len=0 in cycle 0 -> err_len=1 in cycle 1, busy stays 0, no ce activity.
- start pulsed in cycles 2 and 7 during a len=4 job -> ignored; exactly one done; start in cycle 8 (after done) begins a new job.
- rst asserted asynchronously mid-RUN in cycle 3 of a len=4 job -> all outputs 0 immediately; no done; a fresh len=1 job afterwards gives done 4 cycles after its start cycle.
- DSP_SEQ_ABORT_EN: abort in cycle 3 of a len=4 job -> rst_p=1 in cycle 4, busy=0 from cycle 4, no ce_p after cycle 4, no done.

Source files
------------

// File: rtl/dsp_mac_sequencer_if.sv
// Stream and control bundle between a MAC channel's job source and its sequencer.
// The master side issues jobs and operand pairs; the slave side (the sequencer)
// answers with ready, the slice clock enables, the Z-mux select and job status.
interface dsp_mac_sequencer_if #(
   parameter int CNT_W = 10
);
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic             ce_ab;
   logic             ce_m;
   logic             ce_p;
   logic             opmode_acc;
   logic             busy;
   logic             done;
   logic             err_len;

   modport master (
      output start, len, in_valid,
      input  in_ready, ce_ab, ce_m, ce_p, opmode_acc, busy, done, err_len
   );

   modport slave (
      input  start, len, in_valid,
      output in_ready, ce_ab, ce_m, ce_p, opmode_acc, busy, done, err_len
   );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Control sequencer for one multiply-accumulate slice (A/B regs -> M reg -> P reg).
// Accepts a job of len operand pairs, drives the stage clock enables and the
// P-stage load/accumulate select, and pulses done once P holds the final sum.
// Optional build macro DSP_SEQ_ABORT_EN adds a synchronous abort input and an
// rst_p pulse output that clears the P register of the abandoned job.
module dsp_mac_sequencer #(
   parameter int CNT_W = 10
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef DSP_SEQ_ABORT_EN
   input  logic                    abort,
   output logic                    rst_p,
`endif
   dsp_mac_sequencer_if.slave      bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             first_q, first_d;
   logic             v1_q, v1_d;
   logic             v2_q, v2_d;
   logic             f1_q, f1_d;
   logic             f2_q, f2_d;
   logic             err_q, err_d;
`ifdef DSP_SEQ_ABORT_EN
   logic             rst_p_q, rst_p_d;
`endif

   logic             in_ready_w;
   logic             hs;

   // in_ready comes from registered state only, so it never depends on in_valid
   assign in_ready_w = (state_q == RUN);
   assign hs         = bus.in_valid & in_ready_w;

   // Next-state, tap counter and two-stage pipeline occupancy tracking
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      first_d     = first_q;
      err_d       = 1'b0;
      // v tracks a valid pair moving A/B -> M -> P; f marks the job's first pair
      v1_d        = hs;
      f1_d        = first_q & hs;
      v2_d        = v1_q;
      f2_d        = f1_q;
`ifdef DSP_SEQ_ABORT_EN
      rst_p_d     = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.len != '0) begin
                  state_d     = RUN;
                  remaining_d = bus.len;
                  first_d     = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (hs) begin
               remaining_d = remaining_q - CNT_W'(1);
               first_d     = 1'b0;
               // counter is loaded non-zero and leaves RUN at 1, so it never wraps
               if (remaining_q == CNT_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // last pair is in the P stage and nothing follows it
            if (v2_q & ~v1_q) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef DSP_SEQ_ABORT_EN
      // abort drops the job and flushes in-flight pairs; start in IDLE is unaffected
      if (abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         remaining_d = '0;
         first_d     = 1'b0;
         v1_d        = 1'b0;
         f1_d        = 1'b0;
         v2_d        = 1'b0;
         f2_d        = 1'b0;
         rst_p_d     = 1'b1;
      end
`endif
   end

   // State registers; asynchronous reset abandons any job without a done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         first_q     <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         f1_q        <= 1'b0;
         f2_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         first_q     <= first_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         f1_q        <= f1_d;
         f2_q        <= f2_d;
         err_q       <= err_d;
      end
   end

`ifdef DSP_SEQ_ABORT_EN
   // One-cycle P clear following an abort
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_p_q <= 1'b0;
      end else begin
         rst_p_q <= rst_p_d;
      end
   end

   assign rst_p = rst_p_q;
`endif

   assign bus.in_ready   = in_ready_w;
   assign bus.ce_ab      = hs;
   assign bus.ce_m       = v1_q;
   assign bus.ce_p       = v2_q;
   // first pair of a job loads P; later pairs accumulate; 0 whenever ce_p is 0
   assign bus.opmode_acc = v2_q & ~f2_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.err_len    = err_q;

endmodule
